load_store_unit: RTL and testbench
==================================

# load_store_unit

Parametrised successor to the single-cycle byte-lane data memory. It accepts one load or store per valid/ready request and resolves byte, half, word and (optionally) double-word accesses at any byte address. Loads are sign- or zero-extended, misaligned requests are flagged as errors, and the response is returned after a configurable number of wait states. It sits between the execute stage and on-chip data storage, so a multi-cycle core can stall on a slow memory.

## Interface
- LANES, 4: bytes per memory word; legal values 4 or 8; data width is 8*LANES.
- DEPTH_LOG2, 8: log2 of word count; storage holds 2**DEPTH_LOG2 words.
- LATENCY, 1: wait-state cycles inserted before the access completes; legal 0..7.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- rstd  input  1  asynchronous, active-high reset.
- req_valid  input  1  request present.
- req_ready  output  1  unit can accept a request this cycle.
- req_we  input  1  1 = store, 0 = load.
- req_size  input  2  0 = byte, 1 = half, 2 = word (4 B), 3 = double (8 B; LANES=8 only).
- req_signed  input  1  load sign-extends when 1, zero-extends when 0.
- req_addr  input  32  byte address.
- req_wdata  input  8*LANES  store data, right-aligned (LSB-justified).
- rsp_valid  output  1  response present.
- rsp_ready  input  1  consumer accepts the response.
- rsp_rdata  output  8*LANES  load result, right-aligned and extended; 0 for stores and errors.
- rsp_err  output  1  request was misaligned or its size is illegal.

## Operation
- OFS = log2(LANES). Byte offset = req_addr[OFS-1:0]. Word index = req_addr[DEPTH_LOG2+OFS-1:OFS].
- Upper address bits are ignored, so addresses wrap modulo 2**(DEPTH_LOG2+OFS) bytes.
- Alignment:
  - half requires offset[0]=0.
  - word requires offset[1:0]=0.
  - double requires offset=0.
  - size 3 with LANES=4 is illegal.
  - Any violation sets rsp_err=1, performs no write and returns rsp_rdata=0.
- Store: the low 2**size bytes of req_wdata are shifted to lanes offset..offset+2**size-1. Only those lanes are written; all other lanes are unchanged.
- Load:
  - The selected lanes are shifted down to bit 0.
  - Bits above 8*2**size are filled with the top loaded bit when req_signed=1, otherwise with 0.
  - A full-width load ignores req_signed.
- FSM states: IDLE, WAIT, RESP.
  - IDLE: req_ready=1. On req_valid, latch all request fields, load cnt=LATENCY and go to WAIT.
  - WAIT: if cnt≠0, decrement cnt. If cnt=0, perform the access on this edge, register rsp_rdata and rsp_err, and go to RESP.
  - RESP: rsp_valid=1. If rsp_ready=1, go to IDLE; otherwise hold.
- req_ready=0 outside IDLE. Requests presented in WAIT or RESP are not accepted; the requester must keep them stable until accepted.
- Storage contents are not reset and are undefined after power-up.

## Timing
- Request accepted at edge N; the access edge is N+1+LATENCY; rsp_valid is high from that edge on.
- With LATENCY=0, rsp_valid rises one cycle after acceptance.
- rsp_rdata and rsp_err are stable for the whole time rsp_valid=1 and do not change under rsp_ready backpressure.
- Response consumed at edge M (rsp_valid=1 and rsp_ready=1): req_ready=1 from edge M on, and the next accept is at edge M+1 at the earliest.
- Maximum throughput is one request per LATENCY+3 cycles.
- A load issued after a store to the same address returns the stored data; the store commits before RESP.
- Reset values while rstd=1: state IDLE, req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, cnt=0.
- req_ready goes to 1 in the first cycle after rstd deasserts.
- Reset asserted in WAIT before the access edge drops the request, including any store. Writes already committed are retained.
- Reset asserted in RESP discards the response.

## Test plan
- Word round trip: LANES=4, LATENCY=1. Store 0xDEADBEEF to 0x10, then load word from 0x10. Required: rsp_rdata=0xDEADBEEF, rsp_err=0, and rsp_valid rises 2 cycles after each accept.
- Byte store and extension:
  - Store word 0x11223344 to 0x20, then store byte 0x80 to 0x22.
  - Signed byte load from 0x22 returns 0xFFFFFF80; unsigned returns 0x00000080.
  - Word load from 0x20 returns 0x11803344.
- Misalignment: half store of 0xAAAA to 0x21 returns rsp_err=1 and rsp_rdata=0. A following word load from 0x20 still returns 0x11803344. A word load from 0x22 returns rsp_err=1.
- Backpressure: hold rsp_ready=0 for 3 cycles in RESP. Required: rsp_valid, rsp_rdata and rsp_err stay constant, req_ready stays 0, and a new req_valid is not accepted until the cycle after rsp_ready=1.
- Reset mid-operation: LATENCY=3, store 0x55 to 0x30 (word previously 0). Assert rstd in the second WAIT cycle. Required: outputs go to reset values immediately, and a later word load from 0x30 returns 0.
- Wrap and double width:
  - DEPTH_LOG2=8, LANES=4: store to 0x400, then load from 0x000; the stored data is returned.
  - LANES=8: double store 0x0123456789ABCDEF to 0x08 and load it back unchanged.
  - LANES=4: a size=3 request returns rsp_err=1.

Source files
------------

// File: rtl/load_store_unit.sv
// Load/store unit with a byte-lane data store: byte/half/word/double accesses, sign/zero-extended loads, misalignment errors.
// Latency: the access happens LATENCY+1 edges after accept, and the response is valid from that edge; one request per LATENCY+3 cycles at best.
// Backpressure: req_ready is low outside IDLE; the response and its data are held in RESP until rsp_ready.
// Ports:
//   clk, rstd (async, active-high)
//   req_valid/req_ready, req_we, req_size, req_signed, req_addr, req_wdata : request channel
//   rsp_valid/rsp_ready, rsp_rdata, rsp_err                                 : response channel
module load_store_unit #(
  parameter int LANES      = 4,
  parameter int DEPTH_LOG2 = 8,
  parameter int LATENCY    = 1
) (
  input  logic                 clk,
  input  logic                 rstd,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_we,
  input  logic [1:0]           req_size,
  input  logic                 req_signed,
  input  logic [31:0]          req_addr,
  input  logic [8*LANES-1:0]   req_wdata,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [8*LANES-1:0]   rsp_rdata,
  output logic                 rsp_err
);
  localparam int OFS = $clog2(LANES);
  localparam int DW  = 8 * LANES;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic [1:0]            r_state;
  logic [2:0]            r_cnt;
  logic                  r_we;
  logic                  r_signed;
  logic [1:0]            r_size;
  logic [OFS-1:0]        r_ofs;
  logic [DEPTH_LOG2-1:0] r_idx;
  logic [DW-1:0]         r_wdata;
  logic [DW-1:0]         r_rdata;
  logic                  r_err;
  logic [DW-1:0]         r_mem [2**DEPTH_LOG2];

  logic                  w_err;
  logic                  w_access;
  logic                  w_commit;
  int                    w_nbytes;
  int                    w_nbits;
  logic [LANES-1:0]      w_be;
  logic [DW-1:0]         w_wsh;
  logic [DW-1:0]         w_rsh;
  logic                  w_sign;
  logic [DW-1:0]         w_ext;
  logic                  w_unused;

  // Address bits above the store size wrap away.
  assign w_unused = ^req_addr[31:DEPTH_LOG2+OFS];

  // Size 3 is only legal when the word is 8 bytes wide.
  assign w_err = ((r_size == 2'd3) && (LANES == 4)) ||
                 ((r_size == 2'd1) && r_ofs[0]) ||
                 ((r_size == 2'd2) && (r_ofs[1:0] != 2'd0)) ||
                 ((r_size == 2'd3) && (r_ofs != '0));

  assign w_access = (r_state == S_WAIT) && (r_cnt == 3'd0);
  // Gating with rstd keeps a reset that lands on the access edge from committing the store.
  assign w_commit = w_access && r_we && !w_err && !rstd;

  assign w_nbytes = 1 << r_size;
  assign w_nbits  = 8 << r_size;

  assign w_wsh = r_wdata << {r_ofs, 3'b000};
  assign w_rsh = r_mem[r_idx] >> {r_ofs, 3'b000};

  always_comb begin
    w_be = '0;
    for (int i = 0; i < LANES; i++) begin
      w_be[i] = (i >= int'(r_ofs)) && (i < int'(r_ofs) + w_nbytes);
    end
  end

  // Sign source is the top bit of the loaded field; full-width loads have no fill bits.
  always_comb begin
    w_sign = 1'b0;
    case (r_size)
      2'd0:    w_sign = w_rsh[7];
      2'd1:    w_sign = w_rsh[15];
      default: w_sign = w_rsh[31];
    endcase
  end

  always_comb begin
    w_ext = '0;
    for (int j = 0; j < DW; j++) begin
      w_ext[j] = (j < w_nbits) ? w_rsh[j] : (r_signed & w_sign);
    end
  end

  always_ff @(posedge clk or posedge rstd) begin
    if (rstd) begin
      r_state  <= S_IDLE;
      r_cnt    <= 3'd0;
      r_we     <= 1'b0;
      r_signed <= 1'b0;
      r_size   <= 2'd0;
      r_ofs    <= '0;
      r_idx    <= '0;
      r_wdata  <= '0;
      r_rdata  <= '0;
      r_err    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            r_we     <= req_we;
            r_signed <= req_signed;
            r_size   <= req_size;
            r_ofs    <= req_addr[OFS-1:0];
            r_idx    <= req_addr[DEPTH_LOG2+OFS-1:OFS];
            r_wdata  <= req_wdata;
            r_cnt    <= 3'(LATENCY);
            r_state  <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (r_cnt != 3'd0) begin
            r_cnt <= r_cnt - 3'd1;
          end else begin
            r_rdata <= (w_err || r_we) ? '0 : w_ext;
            r_err   <= w_err;
            r_state <= S_RESP;
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Storage is never reset; only the enabled lanes of the addressed word change.
  always_ff @(posedge clk) begin
    if (w_commit) begin
      for (int i = 0; i < LANES; i++) begin
        if (w_be[i]) begin
          r_mem[r_idx][8*i +: 8] <= w_wsh[8*i +: 8];
        end
      end
    end
  end

  assign req_ready = !rstd && (r_state == S_IDLE);
  assign rsp_valid = (r_state == S_RESP);
  assign rsp_rdata = r_rdata;
  assign rsp_err   = r_err;

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;
  // Unit 0: LANES=4 LATENCY=1, unit 1: LANES=4 LATENCY=3, unit 2: LANES=8 LATENCY=0.
  logic        clk;
  logic        rstd;
  logic        req_valid  [3];
  logic        req_ready  [3];
  logic        req_we     [3];
  logic [1:0]  req_size   [3];
  logic        req_signed [3];
  logic [31:0] req_addr   [3];
  logic [63:0] req_wdata  [3];
  logic        rsp_valid  [3];
  logic        rsp_ready  [3];
  logic [63:0] rsp_rdata  [3];
  logic        rsp_err    [3];
  logic [31:0] rd0;
  logic [31:0] rd1;
  logic [63:0] rd2;

  typedef struct {
    int          u;
    int          id;
    logic [63:0] d;
    logic        e;
  } exp_t;

  exp_t q[$];
  exp_t m_e;
  int   total;
  int   bad;
  int   seq;

  assign rsp_rdata[0] = {32'h0, rd0};
  assign rsp_rdata[1] = {32'h0, rd1};
  assign rsp_rdata[2] = rd2;

  load_store_unit #(.LANES(4), .DEPTH_LOG2(8), .LATENCY(1)) u0 (
    .clk(clk), .rstd(rstd),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_we(req_we[0]),
    .req_size(req_size[0]), .req_signed(req_signed[0]), .req_addr(req_addr[0]),
    .req_wdata(req_wdata[0][31:0]),
    .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]), .rsp_rdata(rd0), .rsp_err(rsp_err[0])
  );

  load_store_unit #(.LANES(4), .DEPTH_LOG2(8), .LATENCY(3)) u1 (
    .clk(clk), .rstd(rstd),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_we(req_we[1]),
    .req_size(req_size[1]), .req_signed(req_signed[1]), .req_addr(req_addr[1]),
    .req_wdata(req_wdata[1][31:0]),
    .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]), .rsp_rdata(rd1), .rsp_err(rsp_err[1])
  );

  load_store_unit #(.LANES(8), .DEPTH_LOG2(8), .LATENCY(0)) u2 (
    .clk(clk), .rstd(rstd),
    .req_valid(req_valid[2]), .req_ready(req_ready[2]), .req_we(req_we[2]),
    .req_size(req_size[2]), .req_signed(req_signed[2]), .req_addr(req_addr[2]),
    .req_wdata(req_wdata[2]),
    .rsp_valid(rsp_valid[2]), .rsp_ready(rsp_ready[2]), .rsp_rdata(rd2), .rsp_err(rsp_err[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int lat_of(input int u);
    case (u)
      0:       lat_of = 1;
      1:       lat_of = 3;
      default: lat_of = 0;
    endcase
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Monitor: every accepted response is matched against the oldest expectation.
  always @(negedge clk) begin
    for (int u = 0; u < 3; u++) begin
      if (!rstd && rsp_valid[u] && rsp_ready[u]) begin
        if (q.size() == 0) begin
          chk("unexpected_rsp", 64'(u), 64'hFF);
        end else begin
          m_e = q.pop_front();
          chk($sformatf("rsp_unit#%0d", m_e.id), 64'(u), 64'(m_e.u));
          chk($sformatf("rsp_rdata#%0d", m_e.id), rsp_rdata[u], m_e.d);
          chk($sformatf("rsp_err#%0d", m_e.id), 64'(rsp_err[u]), 64'(m_e.e));
        end
      end
    end
  end

  task automatic issue(input int u, input logic we, input logic [1:0] sz, input logic sg,
                       input logic [31:0] a, input logic [63:0] wd,
                       input logic [63:0] ed, input logic ee, input int hold);
    int n;
    q.push_back('{u: u, id: seq, d: ed, e: ee});
    seq++;
    req_we[u]     = we;
    req_size[u]   = sz;
    req_signed[u] = sg;
    req_addr[u]   = a;
    req_wdata[u]  = wd;
    req_valid[u]  = 1'b1;
    n = 0;
    @(negedge clk);
    while (!req_ready[u] && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready[u]) begin
      chk("accept_timeout", 64'(n), 64'(0));
      req_valid[u] = 1'b0;
      return;
    end
    @(posedge clk);
    #1 req_valid[u] = 1'b0;
    n = 0;
    while (!rsp_valid[u] && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("latency", 64'(n), 64'(lat_of(u) + 1));
    if (hold > 0) begin
      // Stall the response and present the same request again meanwhile.
      rsp_ready[u] = 1'b0;
      req_valid[u] = 1'b1;
      for (int k = 0; k < hold; k++) begin
        @(posedge clk);
        #1;
        chk("bp_valid", 64'(rsp_valid[u]), 64'(1));
        chk("bp_rdata", rsp_rdata[u], ed);
        chk("bp_err", 64'(rsp_err[u]), 64'(ee));
        chk("bp_req_ready", 64'(req_ready[u]), 64'(0));
      end
      rsp_ready[u] = 1'b1;
    end
    n = 0;
    while (rsp_valid[u] && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("rsp_drop", 64'(rsp_valid[u]), 64'(0));
    if (hold > 0) begin
      chk("bp_ready_after", 64'(req_ready[u]), 64'(1));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    total = 0;
    bad   = 0;
    seq   = 0;
    rstd  = 1'b1;
    for (int u = 0; u < 3; u++) begin
      req_valid[u]  = 1'b0;
      req_we[u]     = 1'b0;
      req_size[u]   = 2'd0;
      req_signed[u] = 1'b0;
      req_addr[u]   = 32'h0;
      req_wdata[u]  = 64'h0;
      rsp_ready[u]  = 1'b1;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int u = 0; u < 3; u++) begin
      chk("rst_req_ready", 64'(req_ready[u]), 64'(0));
      chk("rst_rsp_valid", 64'(rsp_valid[u]), 64'(0));
      chk("rst_rsp_rdata", rsp_rdata[u], 64'h0);
      chk("rst_rsp_err", 64'(rsp_err[u]), 64'(0));
    end
    rstd = 1'b0;
    #1;
    chk("post_rst_ready", 64'(req_ready[0]), 64'(1));

    // unit, we, size, signed, addr, wdata, exp rdata, exp err, hold
    issue(0, 1, 2, 0, 32'h10,  64'hDEADBEEF, 64'h0,        0, 0);
    issue(0, 0, 2, 0, 32'h10,  64'h0,        64'hDEADBEEF, 0, 0);
    issue(0, 1, 2, 0, 32'h20,  64'h11223344, 64'h0,        0, 0);
    issue(0, 1, 0, 0, 32'h22,  64'h80,       64'h0,        0, 0);
    issue(0, 0, 0, 1, 32'h22,  64'h0,        64'hFFFFFF80, 0, 0);
    issue(0, 0, 0, 0, 32'h22,  64'h0,        64'h00000080, 0, 0);
    issue(0, 0, 2, 0, 32'h20,  64'h0,        64'h11803344, 0, 0);
    issue(0, 1, 1, 0, 32'h21,  64'hAAAA,     64'h0,        1, 0);
    issue(0, 0, 2, 0, 32'h20,  64'h0,        64'h11803344, 0, 0);
    issue(0, 0, 2, 0, 32'h22,  64'h0,        64'h0,        1, 0);
    issue(0, 1, 1, 0, 32'h12,  64'h1234,     64'h0,        0, 0);
    issue(0, 0, 1, 1, 32'h10,  64'h0,        64'hFFFFBEEF, 0, 0);
    issue(0, 0, 1, 0, 32'h10,  64'h0,        64'h0000BEEF, 0, 0);
    issue(0, 0, 3, 0, 32'h00,  64'h0,        64'h0,        1, 0);
    issue(0, 0, 2, 0, 32'h10,  64'h0,        64'h1234BEEF, 0, 3);
    issue(0, 0, 2, 0, 32'h10,  64'h0,        64'h1234BEEF, 0, 0);
    issue(0, 1, 2, 0, 32'h400, 64'hCAFEF00D, 64'h0,        0, 0);
    issue(0, 0, 2, 0, 32'h000, 64'h0,        64'hCAFEF00D, 0, 0);

    issue(2, 1, 3, 0, 32'h08,  64'h0123456789ABCDEF, 64'h0,                0, 0);
    issue(2, 0, 3, 0, 32'h08,  64'h0,                64'h0123456789ABCDEF, 0, 0);
    issue(2, 0, 2, 1, 32'h08,  64'h0,                64'hFFFFFFFF89ABCDEF, 0, 0);
    issue(2, 0, 2, 1, 32'h0C,  64'h0,                64'h0000000001234567, 0, 0);
    issue(2, 0, 1, 1, 32'h0A,  64'h0,                64'hFFFFFFFFFFFF89AB, 0, 0);
    issue(2, 0, 0, 0, 32'h0F,  64'h0,                64'h0000000000000001, 0, 0);
    issue(2, 0, 3, 0, 32'h0C,  64'h0,                64'h0,                1, 0);

    // Reset during WAIT drops an in-flight byte store.
    issue(1, 1, 2, 0, 32'h30, 64'h0, 64'h0, 0, 0);
    req_we[1]    = 1'b1;
    req_size[1]  = 2'd0;
    req_addr[1]  = 32'h30;
    req_wdata[1] = 64'h55;
    req_valid[1] = 1'b1;
    n = 0;
    @(negedge clk);
    while (!req_ready[1] && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("rst_seq_ready", 64'(req_ready[1]), 64'(1));
    @(posedge clk);
    #1 req_valid[1] = 1'b0;
    @(posedge clk);
    #1 rstd = 1'b1;
    #1;
    chk("midrst_req_ready", 64'(req_ready[1]), 64'(0));
    chk("midrst_rsp_valid", 64'(rsp_valid[1]), 64'(0));
    chk("midrst_rsp_err", 64'(rsp_err[1]), 64'(0));
    chk("midrst_u0_rdata", rsp_rdata[0], 64'h0);
    chk("midrst_u2_rdata", rsp_rdata[2], 64'h0);
    repeat (2) @(posedge clk);
    #1 rstd = 1'b0;
    #1;
    chk("midrst_release_ready", 64'(req_ready[1]), 64'(1));
    chk("midrst_release_valid", 64'(rsp_valid[1]), 64'(0));
    issue(1, 0, 2, 0, 32'h30, 64'h0, 64'h0, 0, 0);

    n = 0;
    while (q.size() != 0 && n < 50) begin
      @(posedge clk);
      n++;
    end
    chk("queue_empty", 64'(q.size()), 64'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
